// File: rtl/tx_engine.sv
// ---------------------------------------------------------------------------
// tx_engine
//
// UART transmit engine. A byte written with LOAD while TXRDY is high is framed
// as start bit, 7 or 8 data bits LSB-first, optional parity, then stop/pad
// marks. It is shifted out on TX at one bit per k+1 clocks. Every frame
// occupies 11 bit times regardless of format.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   k         in   bit-time divisor (bit time = k+1 clocks), used live
//   EIGHT     in   1 = 8 data bits, 0 = 7 data bits   (captured on LOAD)
//   PEN       in   parity enable                      (captured on LOAD)
//   OHEL      in   parity sense, 1 = odd, 0 = even    (captured on LOAD)
//   LOAD      in   single-cycle write strobe for OUT_PORT
//   OUT_PORT  in   byte to send (bit 7 ignored in 7-bit mode)
//   TX        out  serial line, idle high (registered)
//   TXRDY     out  idle and able to accept LOAD (registered)
//
// Handshake: TXRDY acts as ready and LOAD as valid. A transfer happens on a
// rising edge where both are 1. LOAD with TXRDY low is dropped and has no
// effect. TXRDY falls on the accepting edge and rises again on the edge that
// ends bit 10.
// ---------------------------------------------------------------------------
module tx_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic [18:0] k,
   input  logic        EIGHT,
   input  logic        PEN,
   input  logic        OHEL,
   input  logic        LOAD,
   input  logic [7:0]  OUT_PORT,
   output logic        TX,
   output logic        TXRDY
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state;
   logic [7:0]  data_h;
   logic        eight_h;
   logic        pen_h;
   logic        ohel_h;
   logic [10:0] sr;
   logic [18:0] bt_cnt;
   logic [3:0]  bit_cnt;
   logic        doit;
   logic        load_d;   // high for the one cycle between acceptance and sr load

   logic        btu;
   logic        done;
   logic        par;
   logic        bit8;
   logic        bit9;
   logic [10:0] frame;

   assign btu  = doit && (bt_cnt == k);
   assign done = btu && (bit_cnt == 4'd10);

   // Parity covers only the data bits actually sent; OHEL=1 inverts the
   // even-parity result so the total number of ones comes out odd.
   assign par  = (^{eight_h & data_h[7], data_h[6:0]}) ^ ohel_h;
   assign bit8 = eight_h ? data_h[7] : (pen_h ? par : 1'b1);
   assign bit9 = (eight_h && pen_h) ? par : 1'b1;
   assign frame = {1'b1, bit9, bit8, data_h[6:0], 1'b0};

   // TX is taken straight from the shift register flop.
   assign TX = sr[0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         data_h  <= 8'h00;
         eight_h <= 1'b0;
         pen_h   <= 1'b0;
         ohel_h  <= 1'b0;
         sr      <= 11'h7FF;
         bt_cnt  <= 19'd0;
         bit_cnt <= 4'd0;
         doit    <= 1'b0;
         load_d  <= 1'b0;
         TXRDY   <= 1'b1;
      end else begin
         load_d <= 1'b0;
         case (state)
            IDLE: begin
               bt_cnt  <= 19'd0;
               bit_cnt <= 4'd0;
               if (load_d) begin
                  // Holding registers are stable now, so the frame is valid.
                  sr    <= frame;
                  doit  <= 1'b1;
                  state <= SHIFT;
               end else if (LOAD && TXRDY) begin
                  data_h  <= OUT_PORT;
                  eight_h <= EIGHT;
                  pen_h   <= PEN;
                  ohel_h  <= OHEL;
                  TXRDY   <= 1'b0;
                  load_d  <= 1'b1;
               end
            end
            SHIFT: begin
               if (btu) begin
                  sr      <= {1'b1, sr[10:1]};
                  bt_cnt  <= 19'd0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (done) begin
                     doit    <= 1'b0;
                     bit_cnt <= 4'd0;
                     TXRDY   <= 1'b1;
                     state   <= IDLE;
                  end
               end else begin
                  bt_cnt <= bt_cnt + 19'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_tx_engine: directed bench for tx_engine. Each accepted byte pushes its
// hand-computed 11-bit frame (bit i = i-th bit on the line), the divisor and
// the expected start cycle into exp_q. A negedge monitor pops one entry per
// start bit. It checks every bit for exactly k+1 clocks, checks TXRDY low for
// the whole frame, and checks the idle line after the frame.
// ---------------------------------------------------------------------------
module tb_tx_engine;

   localparam int EW = 62;   // {frame[10:0], k[18:0], start_cycle[31:0]}

   logic        clk;
   logic        rst;
   logic [18:0] k;
   logic        eight;
   logic        pen;
   logic        ohel;
   logic        load;
   logic [7:0]  out_port;
   logic        tx;
   logic        txrdy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [EW-1:0] exp_q[$];

   // monitor state
   logic [EW-1:0] cur;
   logic          active = 1'b0;
   logic          post   = 1'b0;
   int            bit_idx;
   int            cnt;

   tx_engine dut (
      .clk      (clk),
      .rst      (rst),
      .k        (k),
      .EIGHT    (eight),
      .PEN      (pen),
      .OHEL     (ohel),
      .LOAD     (load),
      .OUT_PORT (out_port),
      .TX       (tx),
      .TXRDY    (txrdy)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         // Reset drops any frame in flight; nothing more is expected from it.
         active = 1'b0;
         post   = 1'b0;
      end else begin
         if (post) begin
            check("post_txrdy", {31'd0, txrdy}, 32'd1);
            check("post_tx", {31'd0, tx}, 32'd1);
            post = 1'b0;
         end
         if (!active && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_start", 32'd1, 32'd0);
            end else begin
               cur = exp_q.pop_front();
               check("start_cycle", cyc, cur[31:0]);
               active  = 1'b1;
               bit_idx = 0;
               cnt     = 0;
            end
         end
         if (active) begin
            check($sformatf("tx_bit%0d", bit_idx), {31'd0, tx}, {31'd0, cur[51 + bit_idx]});
            check("txrdy_busy", {31'd0, txrdy}, 32'd0);
            cnt++;
            if (cnt == int'(cur[50:32]) + 1) begin
               cnt = 0;
               bit_idx++;
               if (bit_idx == 11) begin
                  active = 1'b0;
                  post   = 1'b1;
               end
            end
         end
      end
   end

   // driver tasks (called at posedge + #1)
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic e, input logic p,
                       input logic o, input logic [10:0] f);
      int t;
      t = 0;
      while (txrdy !== 1'b1 && t < 500) begin
         step(1);
         t++;
      end
      if (txrdy !== 1'b1) begin
         check("txrdy_timeout", 32'd0, 32'd1);
      end else begin
         out_port = d;
         eight    = e;
         pen      = p;
         ohel     = o;
         load     = 1'b1;
         exp_q.push_back({f, k, cyc + 2});
         step(1);
         load     = 1'b0;
         // Flip format inputs so only the captured copies can be right.
         eight    = ~e;
         pen      = ~p;
         ohel     = ~o;
         out_port = ~d;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || active || post || txrdy !== 1'b1) && t < 2000) begin
         step(1);
         t++;
      end
      check("idle_timeout", {31'd0, (exp_q.size() == 0 && !active && !post)}, 32'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      check("abort_tx", {31'd0, tx}, 32'd1);
      check("abort_txrdy", {31'd0, txrdy}, 32'd1);
   endtask

   initial begin
      rst      = 1'b0;
      k        = 19'd3;
      eight    = 1'b1;
      pen      = 1'b0;
      ohel     = 1'b0;
      load     = 1'b0;
      out_port = 8'h00;
      step(3);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_txrdy", {31'd0, txrdy}, 32'd1);

      // LOAD during reset must not be accepted
      load = 1'b1;
      step(1);
      load = 1'b0;
      rst  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("idle_tx", {31'd0, tx}, 32'd1);
         check("idle_txrdy", {31'd0, txrdy}, 32'd1);
         step(1);
      end

      // 8N 0xA5: 0,1,0,1,0,0,1,0,1,1,1
      send(8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A);
      // 8P even 0x03: par 0 -> bit9 = 0
      send(8'h03, 1'b1, 1'b1, 1'b0, 11'h406);
      // 8P odd 0x03: bit9 = 1
      send(8'h03, 1'b1, 1'b1, 1'b1, 11'h606);
      // 7P odd 0xFF: seven ones, bit8 = 0, d7 not sent
      send(8'hFF, 1'b0, 1'b1, 1'b1, 11'h6FE);

      // busy LOAD at N+10 ignored, then back-to-back 0x5A
      send(8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A);
      step(9);
      out_port = 8'h00;
      load     = 1'b1;
      step(1);
      load     = 1'b0;
      send(8'h5A, 1'b1, 1'b0, 1'b0, 11'h6B4);
      wait_idle();

      // reset during data bit 1, k=3, then clean 7N 0x3C
      send(8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A);
      step(6);
      pulse_reset();
      send(8'h3C, 1'b0, 1'b0, 1'b0, 11'h778);
      wait_idle();

      // k=0: reset during data bit 2, then clean 7P even 0x81
      k = 19'd0;
      send(8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A);
      step(3);
      pulse_reset();
      send(8'h81, 1'b0, 1'b1, 1'b0, 11'h702);
      send(8'h03, 1'b1, 1'b1, 1'b1, 11'h606);
      wait_idle();
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
